// File: rtl/rns_pkg.sv
// Shared RNS definitions: FSM state, default moduli, and constant helpers.
// The modular inverse table is computed at elaboration time from the moduli.
package rns_pkg;

  localparam int MAX_DOMAINS = 8;
  localparam int DEF_NUM_DOMAINS = 2;
  localparam logic [17:0] DEF_MODULI = {9'd256, 9'd129};

  typedef enum logic [1:0] {IDLE, DIGIT, ACCUM, DONE} state_t;

  typedef logic [9*MAX_DOMAINS-1:0] moduli_vec_t;

  function automatic int modulus_at(input moduli_vec_t mods, input int idx);
    return int'(mods[idx*9 +: 9]);
  endfunction

  // Brute-force inverse; moduli are at most 256 so the search is short.
  function automatic int modinv(input int a, input int m);
    int ar;
    ar = a % m;
    for (int x = 1; x < m; x++) begin
      if ((ar * x) % m == 1) return x;
    end
    return 0;
  endfunction

  // inv(m_src) modulo m_dst; the diagonal has no inverse and is never used.
  function automatic logic [8:0] inv_pair(input moduli_vec_t mods, input int src, input int dst);
    if (src == dst) return 9'd0;
    return 9'(modinv(modulus_at(mods, src), modulus_at(mods, dst)));
  endfunction

  function automatic longint unsigned moduli_product(input moduli_vec_t mods, input int n);
    longint unsigned p;
    p = 1;
    for (int d = 0; d < n; d++) p = p * longint'(modulus_at(mods, d));
    return p;
  endfunction

endpackage

// File: rtl/rns_mod_submul.sv
// One MRC digit step for modulus m_K: ((w + m - (a mod m)) * inv(m_src, m)) mod m.
// Purely combinational; the inverse row for this modulus is a constant table.
module rns_mod_submul
  import rns_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter logic [9*NUM_DOMAINS-1:0] MODULI = DEF_MODULI,
  parameter int K = 0,
  parameter int KW = 1
) (
  input  logic [7:0]    w,
  input  logic [7:0]    a,
  input  logic [KW-1:0] src,
  output logic [7:0]    y
);

  localparam moduli_vec_t MODS = moduli_vec_t'(MODULI);
  localparam logic [9:0] M10 = 10'(modulus_at(MODS, K));

  logic [8:0]  inv_row [NUM_DOMAINS];
  logic [9:0]  a_red;
  logic [9:0]  diff;
  logic [18:0] prod;

  for (genvar p = 0; p < NUM_DOMAINS; p++) begin : g_inv
    localparam logic [8:0] C = inv_pair(MODS, p, K);
    assign inv_row[p] = C;
  end

  // w < m always, so w + m - (a mod m) stays positive and below 2m.
  always_comb begin
    a_red = {2'b00, a} % M10;
    diff  = {2'b00, w} + M10 - a_red;
    prod  = {9'd0, diff} * {10'd0, inv_row[src]};
    y     = 8'(prod % 19'(M10));
  end

endmodule

// File: rtl/rns_reconstruct.sv
// Residue-to-binary converter using mixed-radix conversion followed by Horner accumulation.
// Digit phase takes N(N-1)/2 cycles, accumulation N-1 cycles; one conversion in flight.
module rns_reconstruct
  import rns_pkg::*;
#(
  parameter int NUM_DOMAINS = DEF_NUM_DOMAINS,
  parameter logic [9*NUM_DOMAINS-1:0] MODULI = DEF_MODULI,
  parameter int TAG_WID = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [8*NUM_DOMAINS-1:0] residues,
  input  logic [TAG_WID-1:0]       in_tag,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*NUM_DOMAINS-1:0] result,
  output logic [TAG_WID-1:0]       out_tag,
  output logic                     busy
);

  localparam int KW = (NUM_DOMAINS > 2) ? $clog2(NUM_DOMAINS) : 1;
  localparam int RW = 8 * NUM_DOMAINS;
  localparam moduli_vec_t MODS = moduli_vec_t'(MODULI);

  if (NUM_DOMAINS < 2 || NUM_DOMAINS > MAX_DOMAINS) begin : g_bad_domains
    $error("rns_reconstruct: NUM_DOMAINS must be between 2 and %0d", MAX_DOMAINS);
  end

  state_t        state;
  logic [7:0]    w     [NUM_DOMAINS];
  logic [7:0]    w_in  [NUM_DOMAINS];
  logic [7:0]    sub_y [NUM_DOMAINS];
  logic [8:0]    mod_tab [NUM_DOMAINS];
  logic [KW-1:0] j, k, i;
  logic [KW-1:0] jm1;
  logic [RW-1:0] acc;
  logic [RW-1:0] horner;

  assign jm1 = j - KW'(1);

  // Per-domain input reduction and digit-step datapath; w_j doubles as MRC digit a_j once final.
  for (genvar g = 0; g < NUM_DOMAINS; g++) begin : g_dom
    localparam logic [8:0] MG = 9'(modulus_at(MODS, g));
    assign mod_tab[g] = MG;
    assign w_in[g] = 8'({1'b0, residues[g*8 +: 8]} % MG);

    rns_mod_submul #(
      .NUM_DOMAINS(NUM_DOMAINS),
      .MODULI     (MODULI),
      .K          (g),
      .KW         (KW)
    ) u_submul (
      .w  (w[g]),
      .a  (w[jm1]),
      .src(jm1),
      .y  (sub_y[g])
    );
  end

  // Horner step: acc * m_i + a_i; bounded by M-1 so RW bits never overflow.
  always_comb begin
    horner = acc * RW'(mod_tab[i]) + RW'(w[i]);
  end

  // Conversion FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      out_tag   <= '0;
      acc       <= '0;
      j         <= '0;
      k         <= '0;
      i         <= '0;
      for (int n = 0; n < NUM_DOMAINS; n++) w[n] <= '0;
    end else if (flush) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            for (int n = 0; n < NUM_DOMAINS; n++) w[n] <= w_in[n];
            out_tag  <= in_tag;
            j        <= KW'(1);
            k        <= KW'(1);
            state    <= DIGIT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        DIGIT: begin
          w[k] <= sub_y[k];
          if (k == KW'(NUM_DOMAINS - 1)) begin
            if (j == KW'(NUM_DOMAINS - 1)) begin
              acc   <= RW'(sub_y[k]);
              i     <= KW'(NUM_DOMAINS - 2);
              state <= ACCUM;
            end else begin
              j <= j + KW'(1);
              k <= j + KW'(1);
            end
          end else begin
            k <= k + KW'(1);
          end
        end
        ACCUM: begin
          acc <= horner;
          i   <= i - KW'(1);
          if (i == '0) begin
            result    <= horner;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
